// File: rtl/rgb_fpga_line_rx.sv
// rgb_fpga_line_rx
// Receiver and decoder for the LED-matrix line stream (shift clock, data,
// latch and output enable). It assembles one 32-bit column word per latch.
// Over a 256-latch PWM frame it counts the on-bits of each column, which
// recovers the 8-bit intensity of that column.
// Optional feature macro: RGB_LINE_RX_OE_CHECK_EN. When it is defined, a
// latch rising edge seen while oe_i is high sets the sticky oe_err flag.
module rgb_fpga_line_rx (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clk_i,
    input  logic            line_i,
    input  logic            lat_i,
    input  logic            oe_i,
    output logic [31:0]     col_q,
    output logic [31:0][7:0] data_o,
    output logic            data_vld,
    output logic            len_err,
    output logic            oe_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] BITS_PER_WORD = 6'd32;
    localparam logic [5:0] BIT_CNT_SAT   = 6'd33;

    state_t           state_q;
    state_t           state_d;
    logic             run;

    logic             clk_i_d;
    logic             lat_i_d;
    logic             rise_clk;
    logic             rise_lat;

    logic [31:0]      sr;
    logic [5:0]       bit_cnt;
    logic [7:0]       lat_cnt;
    logic [31:0][8:0] acc;

    logic [31:0]      sr_upd;
    logic [5:0]       bit_cnt_upd;
    logic             word_ok;
    logic             word_bad;
    logic             frame_end;
    logic [31:0][8:0] acc_sum;
    logic [31:0][7:0] data_next;

    // Two-state controller: RUN while enabled, IDLE otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state follows enable; leaving RUN clears the datapath on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        run = (state_d == RUN);
    end

    // Edge registers keep tracking while disabled, so a level that is already high never looks like a new edge
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_i_d <= 1'b0;
            lat_i_d <= 1'b0;
        end else begin
            clk_i_d <= clk_i;
            lat_i_d <= lat_i;
        end
    end

    assign rise_clk = clk_i & ~clk_i_d;
    assign rise_lat = lat_i & ~lat_i_d;

    // Apply this cycle's shift before the latch looks at the word, so a bit and a latch arriving together count the bit
    always_comb begin
        sr_upd      = sr;
        bit_cnt_upd = bit_cnt;
        if (rise_clk) begin
            if (bit_cnt < BITS_PER_WORD) begin
                sr_upd[bit_cnt[4:0]] = line_i;
            end
            if (bit_cnt != BIT_CNT_SAT) begin
                bit_cnt_upd = bit_cnt + 6'd1;
            end
        end
        word_ok   = rise_lat && (bit_cnt_upd == BITS_PER_WORD);
        word_bad  = rise_lat && (bit_cnt_upd != BITS_PER_WORD);
        frame_end = word_ok && (lat_cnt == 8'hFF);
    end

    // Per-column running count plus the current word, clamped to 8 bits for the frame result
    always_comb begin
        acc_sum   = '0;
        data_next = '0;
        for (int c = 0; c < 32; c++) begin
            acc_sum[c] = acc[c] + {8'd0, sr_upd[c]};
            if (acc_sum[c][8]) begin
                data_next[c] = 8'hFF;
            end else begin
                data_next[c] = acc_sum[c][7:0];
            end
        end
    end

    // Shift, latch and frame bookkeeping; disabling clears everything except the last frame result
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            bit_cnt  <= '0;
            lat_cnt  <= '0;
            acc      <= '0;
            col_q    <= '0;
            data_o   <= '0;
            data_vld <= 1'b0;
            len_err  <= 1'b0;
        end else if (!run) begin
            sr       <= '0;
            bit_cnt  <= '0;
            lat_cnt  <= '0;
            acc      <= '0;
            col_q    <= '0;
            data_vld <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            data_vld <= 1'b0;
            sr       <= sr_upd;
            bit_cnt  <= bit_cnt_upd;
            if (rise_lat) begin
                bit_cnt <= '0;
            end
            if (word_ok) begin
                col_q   <= sr_upd;
                lat_cnt <= lat_cnt + 8'd1;
                if (frame_end) begin
                    data_o   <= data_next;
                    data_vld <= 1'b1;
                    acc      <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end else if (word_bad) begin
                len_err <= 1'b1;
                acc     <= '0;
                lat_cnt <= '0;
            end
        end
    end

`ifdef RGB_LINE_RX_OE_CHECK_EN
    // Sticky flag for a latch edge while the panel outputs are on; the latch itself is still processed
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_err <= 1'b0;
        end else if (!run) begin
            oe_err <= 1'b0;
        end else if (rise_lat && oe_i) begin
            oe_err <= 1'b1;
        end
    end
`else
    logic unused_oe;
    assign unused_oe = oe_i;
    assign oe_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_fpga_line_rx.sv
// tb_rgb_fpga_line_rx
// Directed bench for rgb_fpga_line_rx: a vector table of single words with
// their expected column word and length flag, followed by hand-written
// PWM frame sequences (loop-back patterns, enable clear, mid-frame reset).
module tb_rgb_fpga_line_rx;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             clk_i;
    logic             line_i;
    logic             lat_i;
    logic             oe_i;
    logic [31:0]      col_q;
    logic [31:0][7:0] data_o;
    logic             data_vld;
    logic             len_err;
    logic             oe_err;

    int assert_count = 0;
    int fail_count   = 0;
    int vld_count    = 0;

    logic [7:0]  frame_data [32];
    logic [31:0] first_col;
    logic [31:0] col_254;
    logic        latch_vld;

    typedef struct {
        bit          pre_clear;
        int          nbits;
        logic [31:0] word;
        bit          simul;
        logic [31:0] exp_col;
        logic        exp_len;
    } vec_t;

    vec_t vecs [9];

    rgb_fpga_line_rx dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clk_i    (clk_i),
        .line_i   (line_i),
        .lat_i    (lat_i),
        .oe_i     (oe_i),
        .col_q    (col_q),
        .data_o   (data_o),
        .data_vld (data_vld),
        .len_err  (len_err),
        .oe_err   (oe_err)
    );

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count data_vld pulses away from the active edge
    always @(negedge clk) begin
        if (data_vld === 1'b1) vld_count++;
    end

    // Hard time limit so the run can never hang
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clear_pulse();
        enable = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    // Shift nbits of w (bit 0 first, zeros past bit 31), then latch either with the last bit or one cycle later
    task automatic send_word(input logic [31:0] w, input int nbits, input bit simul);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = (i < 32) ? w[i[4:0]] : 1'b0;
            clk_i  = 1'b1;
            line_i = b;
            if (simul && (i == nbits - 1)) lat_i = 1'b1;
            tick();
            latch_vld = data_vld;
            clk_i = 1'b0;
            lat_i = 1'b0;
            tick();
        end
        if (!simul || nbits == 0) begin
            lat_i = 1'b1;
            tick();
            latch_vld = data_vld;
            lat_i = 1'b0;
            tick();
        end
    endtask

    // Send PWM words 0..nwords-1: column c is on in word l when l < frame_data[c]
    task automatic send_frame(input int nwords);
        logic [31:0] w;
        for (int l = 0; l < nwords; l++) begin
            for (int c = 0; c < 32; c++) w[c] = (l < int'(frame_data[c]));
            send_word(w, 32, 1'b1);
            if (l == 0)   first_col = col_q;
            if (l == 254) col_254   = col_q;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.pre_clear) clear_pulse();
        send_word(v.word, v.nbits, v.simul);
    endtask

    initial begin
        int base;
        logic exp_oe;

        rst    = 1'b1;
        enable = 1'b1;
        clk_i  = 1'b0;
        line_i = 1'b0;
        lat_i  = 1'b0;
        oe_i   = 1'b0;

        vecs[0] = '{1'b0, 32, 32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F, 1'b0};
        vecs[1] = '{1'b0, 32, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 31, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 1'b1};
        vecs[3] = '{1'b0, 32, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1'b1, 35, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 32, 32'h8000_0001, 1'b1, 32'h8000_0001, 1'b0};
        vecs[6] = '{1'b0, 33, 32'h0F0F_0F0F, 1'b0, 32'h8000_0001, 1'b1};
        vecs[7] = '{1'b1, 0,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[8] = '{1'b0, 32, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset col_q", col_q, 32'h0);
        checkOutput("reset data_vld", {31'd0, data_vld}, 32'h0);
        checkOutput("reset len_err", {31'd0, len_err}, 32'h0);
        checkOutput("reset oe_err", {31'd0, oe_err}, 32'h0);
        checkOutput("reset data_o[0]", {24'd0, data_o[0]}, 32'h0);

        // Single-word vector table
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d col_q", i), col_q, vecs[i].exp_col);
            checkOutput($sformatf("vec%0d len_err", i), {31'd0, len_err}, {31'd0, vecs[i].exp_len});
        end

        // Latch while outputs are enabled
`ifdef RGB_LINE_RX_OE_CHECK_EN
        exp_oe = 1'b1;
`else
        exp_oe = 1'b0;
`endif
        clear_pulse();
        oe_i = 1'b1;
        send_word(32'h0000_FFFF, 32, 1'b0);
        oe_i = 1'b0;
        checkOutput("oe latch oe_err", {31'd0, oe_err}, {31'd0, exp_oe});
        checkOutput("oe latch col_q", col_q, 32'h0000_FFFF);
        checkOutput("oe latch len_err", {31'd0, len_err}, 32'h0);

        // Short word restarts the frame, then a full 8*c frame
        clear_pulse();
        send_word(32'hFFFF_FFFF, 31, 1'b0);
        checkOutput("short word len_err", {31'd0, len_err}, 32'h1);
        checkOutput("short word col_q", col_q, 32'h0);
        for (int c = 0; c < 32; c++) frame_data[c] = 8'(8 * c);
        base = vld_count;
        send_frame(256);
        checkOutput("ramp latch data_vld", {31'd0, latch_vld}, 32'h1);
        checkOutput("ramp vld pulses", vld_count - base, 32'd1);
        for (int c = 0; c < 32; c++)
            checkOutput($sformatf("ramp data_o[%0d]", c), {24'd0, data_o[c]}, 8 * c);
        checkOutput("ramp len_err sticky", {31'd0, len_err}, 32'h1);
        checkOutput("ramp oe_err", {31'd0, oe_err}, 32'h0);

        // Enable low clears flags and column but holds the frame result
        clear_pulse();
        checkOutput("clear data_o[31] held", {24'd0, data_o[31]}, 32'd248);
        checkOutput("clear col_q", col_q, 32'h0);
        checkOutput("clear len_err", {31'd0, len_err}, 32'h0);

        // Reset after 100 latches drops the partial frame
        base = vld_count;
        send_frame(100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset data_o[31]", {24'd0, data_o[31]}, 32'h0);
        checkOutput("midreset col_q", col_q, 32'h0);
        checkOutput("midreset no vld", vld_count - base, 32'd0);

        // Full-on frame
        for (int c = 0; c < 32; c++) frame_data[c] = 8'd255;
        base = vld_count;
        send_frame(256);
        checkOutput("full first col_q", first_col, 32'hFFFF_FFFF);
        checkOutput("full word254 col_q", col_254, 32'hFFFF_FFFF);
        checkOutput("full vld pulses", vld_count - base, 32'd1);
        for (int c = 0; c < 32; c++)
            checkOutput($sformatf("full data_o[%0d]", c), {24'd0, data_o[c]}, 32'd255);
        checkOutput("full len_err", {31'd0, len_err}, 32'h0);
        checkOutput("full oe_err", {31'd0, oe_err}, 32'h0);

        // All-off frame follows directly
        for (int c = 0; c < 32; c++) frame_data[c] = 8'd0;
        base = vld_count;
        send_frame(256);
        checkOutput("zero vld pulses", vld_count - base, 32'd1);
        checkOutput("zero col_q", col_q, 32'h0);
        for (int c = 0; c < 32; c++)
            checkOutput($sformatf("zero data_o[%0d]", c), {24'd0, data_o[c]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/rgb_fpga_line_rx.md
# rgb_fpga_line_rx

Serial receiver and decoder for the LED-matrix line stream: the other end of the line driver's clock, data, latch and output-enable interface. It samples the shift-register clock and data and assembles one 32-bit column word per latch pulse. Over a full 256-latch PWM frame it counts per-column on-bits, which recovers the 8-bit intensity of each column. It sits in the verification and loop-back path next to the line driver, and acts as a stand-in for the physical panel shift register.

## Interface
- Parameters: none; width fixed at 32 columns × 8 bit.
- `clk` in 1: system clock, same clock as the line driver.
- `rst` in 1: synchronous reset, active high.
- `enable` in 1: block enable; low acts as a synchronous clear of all state except `data_o`.
- `clk_i` in 1: shift clock from the driver, synchronous to `clk`.
- `line_i` in 1: serial column data.
- `lat_i` in 1: line latch.
- `oe_i` in 1: line output enable, active high.
- `col_q` out 32: last accepted column word; bit k = k-th bit received after the previous latch.
- `data_o` out 32×8: reconstructed intensities; `data_o[c]` is the column c on-count of the last complete frame.
- `data_vld` out 1: one-cycle pulse when `data_o` updates.
- `len_err` out 1: sticky; a latch arrived with ≠32 bits shifted.
- `oe_err` out 1: sticky; a latch rising edge occurred while `oe_i`=1.

## Operation
- Edge detection:
  - `clk_i_d` and `lat_i_d` are registered copies of the inputs.
  - rise_clk = `clk_i & ~clk_i_d`; rise_lat = `lat_i & ~lat_i_d`.
- Shift (on rise_clk):
  - `sr[bit_cnt] <= line_i`.
  - `bit_cnt` (6 bit) increments and saturates at 33 (overflow marker).
- Latch (on rise_lat):
  - If `bit_cnt`==32: `col_q <= sr`. Each 9-bit accumulator `acc[c]` adds `sr[c]`. `lat_cnt` (8 bit) increments.
  - If `bit_cnt`≠32: set `len_err`. Discard the word. Clear `acc` and `lat_cnt` (frame restart).
  - In both cases, clear `bit_cnt` to 0.
- Frame end: when an accepted latch makes `lat_cnt` wrap 255→0:
  - `data_o[c] <= min(acc[c]+sr[c], 255)`.
  - Pulse `data_vld`.
  - Clear `acc`.
- Accumulator saturation: a count of 256 is only reachable with a malformed stream. It is clamped to 255 and does not raise an error.
- Simultaneous rise_clk and rise_lat: the bit is shifted and counted first, then the latch evaluates the updated `bit_cnt`.
- Enable low:
  - Cleared: `sr`, `bit_cnt`, `acc`, `lat_cnt`, `col_q`, both error flags, `data_vld`.
  - `data_o` holds its value.
  - Edge registers still track their inputs, so a level already high at enable does not produce a spurious edge.
- States: IDLE (`enable`=0) and RUN. There are no other FSM states; the counters carry the sequencing.

## Timing
- Reset values:
  - `col_q`=0, `data_o`=0, `data_vld`=0, `len_err`=0, `oe_err`=0.
  - Internal state: `bit_cnt`=0, `lat_cnt`=0, `acc`=0, `clk_i_d`=0, `lat_i_d`=0.
- `line_i` is sampled in the `clk` cycle where rise_clk is true. The driver holds `line_i` stable while `clk_i` is high.
- `col_q` updates 1 `clk` after the cycle in which rise_lat is seen.
- `data_vld` asserts in the same cycle as the corresponding `col_q` update, 1 `clk` after the 256th accepted rise_lat.
- Minimum `clk_i` period is 2 `clk` (driver toggle rate). A `clk_i` held high across cycles counts as one bit.
- `rst` mid-frame: all state returns to reset values on the next edge. Partial frames are lost and `data_vld` is not asserted.
- `len_err` and `oe_err` clear only on `rst` or `enable`=0.

## Configuration
- `RGB_LINE_RX_OE_CHECK_EN`
  - Defined: `oe_err` is set when rise_lat occurs while `oe_i`=1. The latch is still processed normally.
  - Undefined: no `oe_i` logic is compiled; `oe_err` is tied to 0 and `oe_i` is unused.

## Test plan
- Driver loop-back with `data[c]`=8·c (c=0..31), `enable`=1:
  - `data_vld` pulses once per 256 latches.
  - `data_o[c]`=8·c; `data_o[0]`=0, `data_o[31]`=248.
  - `len_err`=0 and `oe_err`=0.
- Driver loop-back with all `data`=255, then all `data`=0:
  - First frame: `data_o` all 255.
  - Second frame: `data_o` all 0.
  - `col_q`=32'hFFFF_FFFF during the first phase.
- Direct stimulus with 31 `clk_i` pulses, then a latch:
  - `len_err`=1; `col_q` is unchanged.
  - A following frame of 256 correct 32-bit words yields valid `data_o`.
- 35 `clk_i` pulses, then a latch: `len_err`=1 (`bit_cnt` saturated at 33).
- rise_clk and rise_lat in the same cycle as the 32nd bit: the word is accepted, `col_q` includes that bit, and `len_err`=0.
- Latch raised with `oe_i`=1:
  - With the macro: `oe_err`=1.
  - Without the macro: `oe_err`=0.
- `rst` asserted after 100 latches: no `data_vld` is produced, and the next 256 latches give a correct frame.
